seq_checker: RTL and testbench

Player-response checker for the Genius game datapath, the reading end of the combinational sequence ROM that maps a 4-bit address to a one-hot colour. It drives the ROM address, takes the player's raw one-hot buttons, synchronises and debounces them, and compares each accepted press against the expected colour. It reports a correct press, a wrong press, or a completed round to the game controller.

---
 rtl/seq_checker.sv | 159 +++++++++++++++
 tb/tb_seq_checker.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_checker.sv
// seq_checker: compares debounced one-hot player presses against the colour
// returned by the sequence ROM. It steps the ROM address through a round and
// reports acerto, erro and fim_rodada pulses to the game controller.
module seq_checker #(
  parameter int DEBOUNCE = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] nivel,
  input  logic [3:0] botoes,
  input  logic [3:0] esperado,
  output logic [3:0] address,
  output logic [3:0] jogada,
  output logic       acerto,
  output logic       erro,
  output logic       fim_rodada,
  output logic       ocupado
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SOLTA  = 2'd1,
    ESPERA = 2'd2
  } state_t;

  localparam logic [7:0] DebMax   = 8'(DEBOUNCE);
  localparam logic [7:0] StableAt = 8'(DEBOUNCE - 1);

  state_t     state_q, state_d;
  logic [3:0] syncMeta_q;
  logic [3:0] sync_q;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] address_q, address_d;
  logic [3:0] nivel_q, nivel_d;
  logic [3:0] jogada_q, jogada_d;
  logic       acerto_q, acerto_d;
  logic       erro_q, erro_d;
  logic       fim_q, fim_d;
  logic       ocupado_q, ocupado_d;
  logic       stable;
  logic       syncOneHot;

  // Two-flop synchroniser bringing the asynchronous buttons into the clock domain
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      syncMeta_q <= '0;
      sync_q     <= '0;
    end else begin
      syncMeta_q <= botoes;
      sync_q     <= syncMeta_q;
    end
  end

  // Stability counter: restarts when sync is about to change, otherwise saturates
  always_comb begin
    cnt_d = cnt_q;
    if (syncMeta_q != sync_q) begin
      cnt_d = '0;
    end else if (cnt_q < DebMax) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Counter register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // sync has held its value for DEBOUNCE cycles once the counter reaches DEBOUNCE-1
  assign stable     = (cnt_q >= StableAt);
  assign syncOneHot = (sync_q != 4'd0) && ((sync_q & (sync_q - 4'd1)) == 4'd0);

  // Next-state and registered-output logic; start overrides whatever the round was doing
  always_comb begin
    state_d   = state_q;
    address_d = address_q;
    nivel_d   = nivel_q;
    jogada_d  = jogada_q;
    acerto_d  = 1'b0;
    erro_d    = 1'b0;
    fim_d     = 1'b0;
    if (start) begin
      state_d   = SOLTA;
      address_d = 4'd0;
      nivel_d   = nivel;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        SOLTA: begin
          if (stable && (sync_q == 4'd0)) begin
            state_d = ESPERA;
          end
        end
        ESPERA: begin
          if (stable && syncOneHot) begin
            jogada_d = sync_q;
            if (sync_q == esperado) begin
              acerto_d = 1'b1;
              if (address_q == nivel_q) begin
                fim_d     = 1'b1;
                address_d = 4'd0;
                state_d   = IDLE;
              end else begin
                address_d = address_q + 4'd1;
                state_d   = SOLTA;
              end
            end else begin
              erro_d    = 1'b1;
              address_d = 4'd0;
              state_d   = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    ocupado_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      address_q <= '0;
      nivel_q   <= '0;
      jogada_q  <= '0;
      acerto_q  <= 1'b0;
      erro_q    <= 1'b0;
      fim_q     <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      address_q <= address_d;
      nivel_q   <= nivel_d;
      jogada_q  <= jogada_d;
      acerto_q  <= acerto_d;
      erro_q    <= erro_d;
      fim_q     <= fim_d;
      ocupado_q <= ocupado_d;
    end
  end

  assign address    = address_q;
  assign jogada     = jogada_q;
  assign acerto     = acerto_q;
  assign erro       = erro_q;
  assign fim_rodada = fim_q;
  assign ocupado    = ocupado_q;

endmodule

// File: tb/tb_seq_checker.sv
// Self-checking bench for seq_checker with DEBOUNCE = 4. A small ROM array
// plays the sequence ROM; expected results are hand-computed in the vector
// table and in the directed sequences below.
module tb_seq_checker;

  logic       clock;
  logic       reset;
  logic       start;
  logic [3:0] nivel;
  logic [3:0] botoes;
  logic [3:0] esperado;
  logic [3:0] address;
  logic [3:0] jogada;
  logic       acerto;
  logic       erro;
  logic       fim_rodada;
  logic       ocupado;

  int compared = 0;
  int mismatched = 0;

  logic [3:0] rom [16];

  typedef struct {
    logic       doStart;
    logic [3:0] nivel;
    logic [3:0] press;
    logic       eAcerto;
    logic       eErro;
    logic       eFim;
    logic [3:0] eJogada;
    logic [3:0] eAddr;
    logic       eOcupado;
  } vec_t;

  vec_t vecs [6];

  seq_checker #(.DEBOUNCE(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .nivel      (nivel),
    .botoes     (botoes),
    .esperado   (esperado),
    .address    (address),
    .jogada     (jogada),
    .acerto     (acerto),
    .erro       (erro),
    .fim_rodada (fim_rodada),
    .ocupado    (ocupado)
  );

  // The sequence ROM is combinational from address
  assign esperado = rom[address];

  // 10-unit clock period
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare one value against its expectation and tally the result
  task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Wait one clock edge and confirm no pulse came out
  task automatic quietCycle(input string name);
    @(posedge clock);
    #1;
    checkOutput(name, {1'b0, acerto, erro, fim_rodada}, 4'd0);
  endtask

  // Drive a new button value and check the press is judged exactly 5 edges after the first sampling edge
  task automatic applyStimulus(input string name, input logic [3:0] val, input logic eA, input logic eE,
                               input logic eF, input logic [3:0] eJ, input logic [3:0] eAd, input logic eO);
    botoes = val;
    for (int k = 0; k < 5; k++) begin
      quietCycle({name, " early"});
    end
    @(posedge clock);
    #1;
    checkOutput({name, " acerto"}, {3'd0, acerto}, {3'd0, eA});
    checkOutput({name, " erro"}, {3'd0, erro}, {3'd0, eE});
    checkOutput({name, " fim"}, {3'd0, fim_rodada}, {3'd0, eF});
    checkOutput({name, " jogada"}, jogada, eJ);
    checkOutput({name, " address"}, address, eAd);
    checkOutput({name, " ocupado"}, {3'd0, ocupado}, {3'd0, eO});
    quietCycle({name, " pulse width"});
  endtask

  // Release all buttons long enough for the checker to return to waiting for a press
  task automatic releaseButtons(input string name);
    botoes = 4'd0;
    for (int k = 0; k < 8; k++) begin
      quietCycle({name, " release"});
    end
  endtask

  // Pulse start for one cycle and confirm the round opened cleanly
  task automatic pulseStart(input string name, input logic [3:0] n);
    nivel = n;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    checkOutput({name, " start ocupado"}, {3'd0, ocupado}, 4'd1);
    checkOutput({name, " start address"}, address, 4'd0);
    checkOutput({name, " start pulses"}, {1'b0, acerto, erro, fim_rodada}, 4'd0);
  endtask

  initial begin
    rom[0]  = 4'b0001; rom[1]  = 4'b0100; rom[2]  = 4'b0010; rom[3]  = 4'b1000;
    rom[4]  = 4'b0001; rom[5]  = 4'b0010; rom[6]  = 4'b0100; rom[7]  = 4'b1000;
    rom[8]  = 4'b0010; rom[9]  = 4'b0001; rom[10] = 4'b1000; rom[11] = 4'b0100;
    rom[12] = 4'b0001; rom[13] = 4'b0001; rom[14] = 4'b0010; rom[15] = 4'b1000;

    // Main round and wrong-press vectors: {start?, nivel, press, acerto, erro, fim, jogada, address, ocupado}
    vecs[0] = '{1'b1, 4'd2, 4'b0001, 1'b1, 1'b0, 1'b0, 4'b0001, 4'd1, 1'b1};
    vecs[1] = '{1'b0, 4'd2, 4'b0100, 1'b1, 1'b0, 1'b0, 4'b0100, 4'd2, 1'b1};
    vecs[2] = '{1'b0, 4'd2, 4'b0010, 1'b1, 1'b0, 1'b1, 4'b0010, 4'd0, 1'b0};
    vecs[3] = '{1'b1, 4'd2, 4'b0001, 1'b1, 1'b0, 1'b0, 4'b0001, 4'd1, 1'b1};
    vecs[4] = '{1'b0, 4'd2, 4'b1000, 1'b0, 1'b1, 1'b0, 4'b1000, 4'd0, 1'b0};
    vecs[5] = '{1'b0, 4'd2, 4'b0100, 1'b0, 1'b0, 1'b0, 4'b1000, 4'd0, 1'b0};

    reset  = 1'b0;
    start  = 1'b0;
    nivel  = 4'd0;
    botoes = 4'd0;

    // Reset state
    #12;
    checkOutput("reset address", address, 4'd0);
    checkOutput("reset jogada", jogada, 4'd0);
    checkOutput("reset flags", {acerto, erro, fim_rodada, ocupado}, 4'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Get mid-round, then assert reset between edges: outputs must clear at once
    pulseStart("mid reset", 4'd2);
    applyStimulus("mid reset press", 4'b0001, 1'b1, 1'b0, 1'b0, 4'b0001, 4'd1, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async reset address", address, 4'd0);
    checkOutput("async reset jogada", jogada, 4'd0);
    checkOutput("async reset flags", {acerto, erro, fim_rodada, ocupado}, 4'd0);
    botoes = 4'd0;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Button activity without start is ignored
    applyStimulus("idle press", 4'b0100, 1'b0, 1'b0, 1'b0, 4'b0000, 4'd0, 1'b0);
    releaseButtons("idle");

    // Table-driven full round, then a wrong press and a press after the round ended
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].doStart) begin
        pulseStart($sformatf("vec%0d", i), vecs[i].nivel);
      end
      applyStimulus($sformatf("vec%0d", i), vecs[i].press, vecs[i].eAcerto, vecs[i].eErro,
                    vecs[i].eFim, vecs[i].eJogada, vecs[i].eAddr, vecs[i].eOcupado);
      releaseButtons($sformatf("vec%0d", i));
    end

    // Bounce: a 3-cycle glitch is too short, a two-button chord is never accepted
    pulseStart("bounce", 4'd2);
    botoes = 4'b0010;
    for (int k = 0; k < 3; k++) quietCycle("glitch");
    botoes = 4'b0000;
    for (int k = 0; k < 10; k++) quietCycle("after glitch");
    checkOutput("glitch address", address, 4'd0);
    botoes = 4'b0011;
    for (int k = 0; k < 20; k++) quietCycle("chord");
    checkOutput("chord ocupado", {3'd0, ocupado}, 4'd1);
    applyStimulus("chord to single", 4'b0010, 1'b0, 1'b1, 1'b0, 4'b0010, 4'd0, 1'b0);
    releaseButtons("bounce");

    // A button held across start must be released before it counts
    botoes = 4'b0001;
    for (int k = 0; k < 8; k++) quietCycle("held pre-start");
    pulseStart("held", 4'd5);
    for (int k = 0; k < 20; k++) quietCycle("held after start");
    checkOutput("held address", address, 4'd0);
    releaseButtons("held");
    for (int s = 0; s < 3; s++) begin
      applyStimulus($sformatf("held step%0d", s), rom[s], 1'b1, 1'b0, 1'b0, rom[s], 4'(s + 1), 1'b1);
      releaseButtons($sformatf("held step%0d", s));
    end
    checkOutput("before restart address", address, 4'd3);

    // Restart at address 3 goes back to step 0 silently
    pulseStart("restart", 4'd5);
    for (int k = 0; k < 10; k++) quietCycle("after restart");
    applyStimulus("restart step0", rom[0], 1'b1, 1'b0, 1'b0, rom[0], 4'd1, 1'b1);
    releaseButtons("restart");

    // Longest round: nivel changed right after start must not shorten it
    pulseStart("nivel15", 4'd15);
    nivel = 4'd0;
    for (int s = 0; s < 16; s++) begin
      applyStimulus($sformatf("nivel15 step%0d", s), rom[s], 1'b1, 1'b0, (s == 15),
                    rom[s], (s == 15) ? 4'd0 : 4'(s + 1), (s != 15));
      releaseButtons($sformatf("nivel15 step%0d", s));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
